block_data_memory: RTL and testbench
====================================

Name: block_data_memory

Overview:
- Parametrised, cycle-accurate block-transfer data memory that sits behind the data cache.
- Replaces fixed delay-based access with a counter-driven state machine.
- Serves one whole block (BLOCK_BYTES bytes) per READ/WRITE request, after a configurable latency, using a BUSYWAIT handshake.
- Adds error signalling for illegal requests and a synthesizable single-port array.

Parameters:
- ADDR_WIDTH, 28, block address width (byte address with block offset removed)
- BLOCK_BYTES, 16, bytes per block; power of two, ≥4
- DEPTH, 1024, number of blocks implemented; must be ≤ 2^ADDR_WIDTH
- LATENCY, 5, cycles from request sample to memory operation; ≥1

Ports:
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous active-low reset
- READ  in  1  block read request; held until BUSYWAIT falls
- WRITE  in  1  block write request; held until BUSYWAIT falls
- ADDRESS  in  ADDR_WIDTH  block address
- IN  in  8*BLOCK_BYTES  write data; byte k at bits [8k+7:8k]
- OUT  out  8*BLOCK_BYTES  read data, registered
- BUSYWAIT  out  1  stall to requester
- ERROR  out  1  illegal request flag, valid while in DONE

Behaviour:
- Reset values (async, on RESET_N low):
  - state = IDLE; counter = 0; OUT = 0; ERROR = 0; BUSYWAIT forced 0.
  - Array contents are not cleared.
- States: IDLE, ACCESS, DONE.
- BUSYWAIT = (READ | WRITE) & (state != DONE). It is combinational and falls in the DONE cycle only.
- IDLE, at rising edge with READ | WRITE:
  - Latch ADDRESS, IN and direction.
  - READ & WRITE both high, or ADDRESS ≥ DEPTH: go to DONE with ERROR = 1. No array access; OUT unchanged.
  - Otherwise go to ACCESS with counter = LATENCY-1.
- ACCESS, at each edge:
  - counter ≠ 0: decrement.
  - counter == 0: perform the operation and go to DONE with ERROR = 0.
    - Read: OUT <= array[addr].
    - Write: array[addr] <= latched IN.
- Timing: request sampled at edge T0 → operation at edge T0+LATENCY → DONE for one cycle → IDLE at T0+LATENCY+1.
- DONE: unconditionally returns to IDLE at the next edge.
  - Requester must drop or retarget READ/WRITE at that edge.
  - A request still high is treated as a new request in IDLE on the following edge.
- Input changes during ACCESS are ignored; latched values are used.
- OUT holds its value until the next successful read.
- Reset mid-ACCESS: a pending write is discarded (array unchanged), and OUT = 0.
- Index arithmetic: array index = ADDRESS[$clog2(DEPTH)-1:0]. The range check uses the full ADDRESS, so there is no wrap-around aliasing.

Optional Feature:
- Macro: DATA_MEMORY_WSTRB_EN.
- Defined:
  - Adds input port WSTRB, width BLOCK_BYTES, latched with the request.
  - A write updates only bytes k where WSTRB[k] = 1; other bytes keep their old value.
  - WSTRB = 0 is legal: full latency, no change.
- Undefined:
  - No WSTRB port; every write replaces the whole block.

Decomposition:
- Package data_memory_pkg holds:
  - state enum (IDLE/ACCESS/DONE);
  - default parameter constants;
  - function for block bit width (8*BLOCK_BYTES).
- Sub-module mem_block_array:
  - single-port synchronous array, DEPTH x 8*BLOCK_BYTES;
  - per-byte write enables and registered read;
  - instantiated once.
- FSM, counter and range check live in block_data_memory.

Test Plan:
- Write then read, LATENCY=5:
  - WRITE, ADDRESS=0x3, IN=0x00112233_44556677_8899AABB_CCDDEEFF → BUSYWAIT high 5 cycles, low in DONE.
  - Then READ, ADDRESS=0x3 → OUT equals the written value at T0+5, ERROR=0.
- READ and WRITE asserted together, ADDRESS=0x10 → DONE at T0+1, ERROR=1, array[0x10] and OUT unchanged.
- ADDRESS=DEPTH (1024) with READ → ERROR=1 one cycle after request, OUT unchanged. Address 0 is not aliased.
- RESET_N pulled low at T0+2 of a WRITE to 0x7 → OUT=0, BUSYWAIT=0, state IDLE; read of 0x7 returns the prior contents.
- Back-to-back: READ held through DONE → second access starts at T0+LATENCY+1 and completes at T0+2*LATENCY+1. LATENCY=1 gives a 2-cycle turnaround.
- With DATA_MEMORY_WSTRB_EN, WSTRB=0x0001, IN byte0=0xA5 over block 0x2 holding all 0xFF → read returns 0xFF..FFA5.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and defaults for the block-transfer data memory.
package data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH  = 28;
    localparam int DEF_BLOCK_BYTES = 16;
    localparam int DEF_DEPTH       = 1024;
    localparam int DEF_LATENCY     = 5;

    function automatic int block_bits(input int block_bytes);
        return 8 * block_bytes;
    endfunction

endpackage

// File: rtl/mem_block_array.sv
// Single-port DEPTH x BLOCK_BYTES byte array: per-byte write enables, registered read.
module mem_block_array #(
    parameter int DEPTH       = 1024,
    parameter int BLOCK_BYTES = 16,
    parameter int IDX_W       = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rd_en,
    input  logic [BLOCK_BYTES-1:0]      wr_en,
    input  logic [IDX_W-1:0]            idx,
    input  logic [BLOCK_BYTES-1:0][7:0] wdata,
    output logic [BLOCK_BYTES-1:0][7:0] rdata
);

    logic [BLOCK_BYTES-1:0][7:0] mem [DEPTH];

    // Storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (wr_en[k]) mem[idx][k] <= wdata[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata <= '0;
        else if (rd_en) rdata <= mem[idx];
    end

endmodule

// File: rtl/block_data_memory.sv
// Block data memory: counter-driven IDLE/ACCESS/DONE FSM with BUSYWAIT handshake.
// Define DATA_MEMORY_WSTRB_EN to add the per-byte WSTRB write mask port.
module block_data_memory
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                                CLOCK,
    input  logic                                RESET_N,
    input  logic                                READ,
    input  logic                                WRITE,
    input  logic [ADDR_WIDTH-1:0]               ADDRESS,
    input  logic [block_bits(BLOCK_BYTES)-1:0]  IN,
`ifdef DATA_MEMORY_WSTRB_EN
    input  logic [BLOCK_BYTES-1:0]              WSTRB,
`endif
    output logic [block_bits(BLOCK_BYTES)-1:0]  OUT,
    output logic                                BUSYWAIT,
    output logic                                ERROR
);

    localparam int BW    = block_bits(BLOCK_BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

    typedef struct packed {
        logic                   wr;
        logic [IDX_W-1:0]       idx;
        logic [BW-1:0]          data;
        logic [BLOCK_BYTES-1:0] strb;
    } req_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] counter, counter_nxt;
    logic             error, error_nxt;
    req_t             req, req_nxt;
    logic             op_en;
    logic [BLOCK_BYTES-1:0] strb_in;
    logic             illegal;

`ifdef DATA_MEMORY_WSTRB_EN
    assign strb_in = WSTRB;
`else
    assign strb_in = '1;
`endif

    // Range check on the full address so out-of-range blocks never alias low ones.
    assign illegal = (READ & WRITE) | ({1'b0, ADDRESS} >= DEPTH_W);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            counter <= '0;
            error   <= 1'b0;
            req     <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            error   <= error_nxt;
            req     <= req_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        error_nxt   = error;
        req_nxt     = req;
        op_en       = 1'b0;
        case (state)
            IDLE: begin
                if (READ | WRITE) begin
                    req_nxt = '{wr: WRITE, idx: ADDRESS[IDX_W-1:0], data: IN, strb: strb_in};
                    if (illegal) begin
                        state_nxt = DONE;
                        error_nxt = 1'b1;
                    end else begin
                        state_nxt   = ACCESS;
                        counter_nxt = CNT_INIT;
                        error_nxt   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (counter != '0) begin
                    counter_nxt = counter - CNT_W'(1);
                end else begin
                    op_en     = 1'b1;
                    state_nxt = DONE;
                    error_nxt = 1'b0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                error_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    mem_block_array #(
        .DEPTH       (DEPTH),
        .BLOCK_BYTES (BLOCK_BYTES),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .rd_en (op_en & ~req.wr),
        .wr_en ({BLOCK_BYTES{op_en & req.wr}} & req.strb),
        .idx   (req.idx),
        .wdata (req.data),
        .rdata (OUT)
    );

    assign BUSYWAIT = RESET_N & (READ | WRITE) & (state != DONE);
    assign ERROR    = error;

endmodule

// File: tb/tb_block_data_memory.sv
// Directed self-checking bench for block_data_memory (LATENCY=5 main instance, LATENCY=1 side instance).
module tb_block_data_memory;

    localparam int AW = 28, BB = 16, DEP = 1024, LAT = 5, BW = 8 * BB;
    localparam int AW1 = 8, BB1 = 4, DEP1 = 16, BW1 = 8 * BB1;

    localparam logic [BW-1:0] V1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [BW-1:0] V2 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [BW-1:0] V3 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [BW-1:0] V4 = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    localparam logic [BW-1:0] V5 = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          rd, wr, busy, err;
    logic [AW-1:0] addr;
    logic [BW-1:0] din, dout;
    logic [BB-1:0] strb;

    logic           r1, w1, bw1, e1;
    logic [AW1-1:0] a1;
    logic [BW1-1:0] d1, o1;
    logic [BB1-1:0] s1;

    int checks = 0;
    int fails  = 0;
    int n;

    block_data_memory #(.ADDR_WIDTH(AW), .BLOCK_BYTES(BB), .DEPTH(DEP), .LATENCY(LAT)) u_dut (
        .CLOCK(clk), .RESET_N(rst_n), .READ(rd), .WRITE(wr), .ADDRESS(addr), .IN(din),
`ifdef DATA_MEMORY_WSTRB_EN
        .WSTRB(strb),
`endif
        .OUT(dout), .BUSYWAIT(busy), .ERROR(err)
    );

    block_data_memory #(.ADDR_WIDTH(AW1), .BLOCK_BYTES(BB1), .DEPTH(DEP1), .LATENCY(1)) u_dut_l1 (
        .CLOCK(clk), .RESET_N(rst_n), .READ(r1), .WRITE(w1), .ADDRESS(a1), .IN(d1),
`ifdef DATA_MEMORY_WSTRB_EN
        .WSTRB(s1),
`endif
        .OUT(o1), .BUSYWAIT(bw1), .ERROR(e1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Clocks edges from the request-sampling edge until BUSYWAIT drops; a legal access takes LAT+1.
    task automatic run_main;
        n = 0;
        do begin tick(); n++; end while (busy && n < 40);
    endtask

    task automatic run_l1;
        n = 0;
        do begin tick(); n++; end while (bw1 && n < 40);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
        wr = 1'b1; addr = a; din = d;
        run_main();
        wr = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd = 1'b1; addr = a;
        run_main();
        rd = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rd = 1'b1; wr = 1'b0; addr = '0; din = '0; strb = '1;
        r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0; s1 = '1;
        rst_n = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (dout !== '0)   begin fails++; $display("FAIL reset_out got %h want 0", dout); end
        checks++; if (err !== 1'b0)  begin fails++; $display("FAIL reset_err got %b want 0", err); end
        rd = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read;
        wr = 1'b1; addr = 28'h3; din = V1;
        #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_idle got %b want 1", busy); end
        run_main();
        checks++; if (n !== LAT + 1) begin fails++; $display("FAIL wr_latency got %0d want %0d", n, LAT + 1); end
        checks++; if (err !== 1'b0)  begin fails++; $display("FAIL wr_err got %b want 0", err); end
        checks++; if (dout !== '0)   begin fails++; $display("FAIL wr_out_untouched got %h want 0", dout); end
        wr = 1'b0;
        tick();
        rd = 1'b1; addr = 28'h3;
        run_main();
        checks++; if (n !== LAT + 1) begin fails++; $display("FAIL rd_latency got %0d want %0d", n, LAT + 1); end
        checks++; if (dout !== V1)   begin fails++; $display("FAIL rd_data got %h want %h", dout, V1); end
        checks++; if (err !== 1'b0)  begin fails++; $display("FAIL rd_err got %b want 0", err); end
        rd = 1'b0;
        tick();
    endtask

    task automatic test_rw_both;
        do_write(28'h10, V2);
        rd = 1'b1; wr = 1'b1; addr = 28'h10; din = V5;
        run_main();
        checks++; if (n !== 1)      begin fails++; $display("FAIL both_latency got %0d want 1", n); end
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL both_err got %b want 1", err); end
        checks++; if (dout !== V1)  begin fails++; $display("FAIL both_out got %h want %h", dout, V1); end
        rd = 1'b0; wr = 1'b0;
        tick();
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL both_err_clear got %b want 0", err); end
        do_read(28'h10);
        checks++; if (dout !== V2)  begin fails++; $display("FAIL both_array got %h want %h", dout, V2); end
    endtask

    task automatic test_out_of_range;
        logic [AW-1:0] bad [2];
        bad[0] = 28'd1024;
        bad[1] = 28'h8000000;
        do_write(28'h0, V3);
        for (int i = 0; i < 2; i++) begin
            rd = 1'b1; addr = bad[i];
            run_main();
            checks++; if (n !== 1)      begin fails++; $display("FAIL oor_latency[%0d] got %0d want 1", i, n); end
            checks++; if (err !== 1'b1) begin fails++; $display("FAIL oor_err[%0d] got %b want 1", i, err); end
            checks++; if (dout !== V2)  begin fails++; $display("FAIL oor_out[%0d] got %h want %h", i, dout, V2); end
            rd = 1'b0;
            tick();
        end
        rd = 1'b1; addr = 28'd1023;
        run_main();
        checks++; if (n !== LAT + 1 || err !== 1'b0) begin fails++; $display("FAIL last_legal got n=%0d err=%b want n=%0d err=0", n, err, LAT + 1); end
        rd = 1'b0;
        tick();
        do_read(28'h0);
        checks++; if (dout !== V3) begin fails++; $display("FAIL no_alias got %h want %h", dout, V3); end
    endtask

    task automatic test_reset_mid;
        do_write(28'h7, V4);
        wr = 1'b1; addr = 28'h7; din = V5;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++; if (dout !== '0)   begin fails++; $display("FAIL rmid_out got %h want 0", dout); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
        wr = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        do_read(28'h7);
        checks++; if (dout !== V4)   begin fails++; $display("FAIL rmid_array got %h want %h", dout, V4); end
    endtask

    task automatic test_back_to_back;
        rd = 1'b1; addr = 28'h3;
        run_main();
        checks++; if (n !== LAT + 1 || dout !== V1) begin fails++; $display("FAIL b2b_first got n=%0d out=%h want n=%0d out=%h", n, dout, LAT + 1, V1); end
        addr = 28'h10;
        tick();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_rise got %b want 1", busy); end
        run_main();
        checks++; if (n !== LAT + 1) begin fails++; $display("FAIL b2b_second_latency got %0d want %0d", n, LAT + 1); end
        checks++; if (dout !== V2)   begin fails++; $display("FAIL b2b_second_data got %h want %h", dout, V2); end
        rd = 1'b0;
        tick();
    endtask

    task automatic test_latency1;
        w1 = 1'b1; a1 = 8'h5; d1 = 32'hDEADBEEF;
        run_l1();
        checks++; if (n !== 2) begin fails++; $display("FAIL l1_write_latency got %0d want 2", n); end
        w1 = 1'b0; r1 = 1'b1;
        tick();
        checks++; if (bw1 !== 1'b1) begin fails++; $display("FAIL l1_busy_rise got %b want 1", bw1); end
        run_l1();
        checks++; if (n !== 2)               begin fails++; $display("FAIL l1_turnaround got %0d want 2", n); end
        checks++; if (o1 !== 32'hDEADBEEF)   begin fails++; $display("FAIL l1_data got %h want deadbeef", o1); end
        checks++; if (e1 !== 1'b0)           begin fails++; $display("FAIL l1_err got %b want 0", e1); end
        r1 = 1'b0;
        tick();
    endtask

`ifdef DATA_MEMORY_WSTRB_EN
    task automatic test_wstrb;
        strb = '1;
        do_write(28'h2, {BW{1'b1}});
        strb = 16'h0001;
        do_write(28'h2, 128'hA5);
        strb = 16'h0000;
        wr = 1'b1; addr = 28'h2; din = '0;
        run_main();
        checks++; if (n !== LAT + 1) begin fails++; $display("FAIL wstrb_zero_latency got %0d want %0d", n, LAT + 1); end
        wr = 1'b0;
        tick();
        strb = '1;
        do_read(28'h2);
        checks++; if (dout !== {{120{1'b1}}, 8'hA5}) begin fails++; $display("FAIL wstrb_merge got %h want ff..ffa5", dout); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_rw_both();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_latency1();
`ifdef DATA_MEMORY_WSTRB_EN
        test_wstrb();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
